// File: rtl/aes_pkg.sv
// Shared AES encodings, FSM states and GF(2^8) round-function helpers.
// S-boxes are computed arithmetically (inverse in GF(2^8) plus affine map) instead of stored as tables.
package aes_pkg;

    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        KL_INVALID = 2'd0,
        KL_128     = 2'd1,
        KL_192     = 2'd2,
        KL_256     = 2'd3
    } key_len_e;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        KEY0,
        ROUND,
        OUT
    } state_e;

    function automatic logic [3:0] nr(input logic [1:0] key_len);
        case (key_len)
            KL_128:  return 4'd10;
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s, input logic inv);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++)
            r[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s, input logic inv);
        logic [BLK_W-1:0] r;
        int unsigned src;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned rw = 0; rw < 4; rw++) begin
                src = inv ? (c + 4 - rw) % 4 : (c + rw) % 4;
                r[127-32*c-8*rw -: 8] = s[127-32*src-8*rw -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] mix_cols(input logic [BLK_W-1:0] s, input logic inv);
        logic [BLK_W-1:0] r;
        logic [7:0] a [4];
        logic [7:0] m0, m1, m2, m3;
        r  = '0;
        m0 = inv ? 8'h0e : 8'h02;
        m1 = inv ? 8'h0b : 8'h03;
        m2 = inv ? 8'h0d : 8'h01;
        m3 = inv ? 8'h09 : 8'h01;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int unsigned k = 0; k < 4; k++)
                r[127-32*c-8*k -: 8] = gf_mul(m0, a[2'(k)]) ^ gf_mul(m1, a[2'(k + 1)]) ^
                                       gf_mul(m2, a[2'(k + 2)]) ^ gf_mul(m3, a[2'(k + 3)]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_block_queue.sv
// Input block FIFO carrying packed {data, mode, key_len}; supports push and pop on one edge.
module aes_block_queue
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = BLK_W + 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_blk,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_blk,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign push   = wr_en && (!full || rd_en) && !flush;
    assign pop    = rd_en && !empty && !flush;
    assign rd_blk = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_blk;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 encrypt/decrypt core, one round per clock, with
// round keys fetched from an external key-schedule store.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int unsigned INPUT_DEPTH = 2,
    parameter int unsigned KADDR_W     = 4,
    parameter bit          SUPPORT_DEC = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLK_W-1:0]   in_data,
    input  logic               in_mode,
    input  logic [1:0]         in_key_len,
    input  logic [BLK_W-1:0]   subkey,
    input  logic               subkey_valid,
    output logic [KADDR_W-1:0] subkey_addr,
    output logic               subkey_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLK_W-1:0]   out_data,
    output logic               out_err,
    output logic               busy
);

    state_e               state_q, state_d;
    logic                 q_full, q_empty, q_pop, q_push;
    logic [BLK_W+2:0]     head;
    logic [BLK_W-1:0]     head_data, st, round_res, enc_sr, dec_ark;
    logic                 head_mode, head_err, mode_q, last_round;
    logic [1:0]           head_kl, kl_q;
    logic [KADDR_W-1:0]   addr_step;

    assign in_ready  = !q_full;
    assign q_push    = in_valid && in_ready && !flush;
    assign head_data = head[BLK_W+2:3];
    assign head_mode = head[2];
    assign head_kl   = head[1:0];
    assign head_err  = (head_kl == KL_INVALID) || (head_mode == MODE_DEC && !SUPPORT_DEC);

    aes_block_queue #(
        .DEPTH (INPUT_DEPTH),
        .WIDTH (BLK_W + 3)
    ) u_queue (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .wr_en  (q_push),
        .wr_blk ({in_data, in_mode, in_key_len}),
        .rd_en  (q_pop),
        .rd_blk (head),
        .full   (q_full),
        .empty  (q_empty)
    );

    assign subkey_req = (state_q == KEY0) || (state_q == ROUND);
    assign busy       = (state_q != IDLE) || !q_empty;
    assign last_round = (mode_q == MODE_DEC) ? (subkey_addr == '0)
                                             : (subkey_addr == KADDR_W'(nr(kl_q)));
    assign addr_step  = (mode_q == MODE_DEC) ? subkey_addr - KADDR_W'(1)
                                             : subkey_addr + KADDR_W'(1);

    // Decrypt adds the round key before InvMixColumns, so standard forward round keys are used
    always_comb begin
        enc_sr    = shift_rows(sub_bytes(st, 1'b0), 1'b0);
        dec_ark   = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ subkey;
        round_res = '0;
        if (mode_q == MODE_DEC)
            round_res = last_round ? dec_ark : mix_cols(dec_ark, 1'b1);
        else
            round_res = (last_round ? enc_sr : mix_cols(enc_sr, 1'b0)) ^ subkey;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        q_pop   = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (!q_empty) begin
                    q_pop   = 1'b1;
                    state_d = head_err ? OUT : KEY0;
                end
                KEY0:  if (subkey_valid) state_d = ROUND;
                ROUND: if (subkey_valid && last_round) state_d = OUT;
                OUT:   if (out_valid && out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Error results enter OUT with out_valid low; it is raised on the first OUT cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= '0;
            mode_q      <= 1'b0;
            kl_q        <= '0;
            subkey_addr <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_err     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (!q_empty) begin
                    st     <= head_data;
                    mode_q <= head_mode;
                    kl_q   <= head_kl;
                    if (head_err) begin
                        out_err  <= 1'b1;
                        out_data <= '0;
                    end else begin
                        subkey_addr <= (head_mode == MODE_DEC) ? KADDR_W'(nr(head_kl)) : '0;
                    end
                end
                KEY0: if (subkey_valid) begin
                    st          <= st ^ subkey;
                    subkey_addr <= addr_step;
                end
                ROUND: if (subkey_valid) begin
                    if (last_round) begin
                        out_data  <= round_res;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        st          <= round_res;
                        subkey_addr <= addr_step;
                    end
                end
                OUT: begin
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Self-checking bench for aes_cipher_core: acts as the round-key store and
// compares results against a byte-array AES reference model.
module tb_aes_cipher_core;

    localparam int KADDR_W = 4;

    logic               clk = 1'b0;
    logic               reset, flush, in_valid, in_mode, out_ready;
    logic               subkey_valid = 1'b1;
    logic               in_ready, subkey_req, out_valid, out_err, busy;
    logic [127:0]       in_data, subkey, out_data;
    logic [1:0]         in_key_len;
    logic [KADDR_W-1:0] subkey_addr;

    logic [127:0] rk [16];
    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    int           checks = 0;
    int           errors = 0;
    bit           gaps = 1'b0;

    always #5 clk = ~clk;

    assign subkey = rk[subkey_addr];

    always @(negedge clk) subkey_valid <= gaps ? ($urandom_range(0, 99) >= 30) : 1'b1;

    aes_cipher_core #(
        .INPUT_DEPTH (2),
        .KADDR_W     (KADDR_W),
        .SUPPORT_DEC (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_mode      (in_mode),
        .in_key_len   (in_key_len),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_addr  (subkey_addr),
        .subkey_req   (subkey_req),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err      (out_err),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) r = r ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic init_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic set_key(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        int nk, nrr;
        nk  = (kl == 2'd1) ? 4 : (kl == 2'd2) ? 6 : 8;
        nrr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nrr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nrr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] tmix(input logic [127:0] v, input bit inv);
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = v[127-32*c -: 32];
            if (!inv)
                v[127-32*c -: 32] = {gmul(a0,2)^gmul(a1,3)^a2^a3, a0^gmul(a1,2)^gmul(a2,3)^a3,
                                     a0^a1^gmul(a2,2)^gmul(a3,3), gmul(a0,3)^a1^a2^gmul(a3,2)};
            else
                v[127-32*c -: 32] = {gmul(a0,14)^gmul(a1,11)^gmul(a2,13)^gmul(a3,9),
                                     gmul(a0,9)^gmul(a1,14)^gmul(a2,11)^gmul(a3,13),
                                     gmul(a0,13)^gmul(a1,9)^gmul(a2,14)^gmul(a3,11),
                                     gmul(a0,11)^gmul(a1,13)^gmul(a2,9)^gmul(a3,14)};
        end
        return v;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] din, input logic dec, input int nrr);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] v;
        int           kidx;
        v = din ^ rk[dec ? nrr : 0];
        for (int round = 1; round <= nrr; round++) begin
            kidx = dec ? nrr - round : round;
            for (int i = 0; i < 16; i++) s[i] = v[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (!dec) u[r+4*c] = sb[s[r+4*((c+r)%4)]];
                    else      u[r+4*((c+r)%4)] = isb[s[r+4*c]];
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = u[i];
            if (!dec) begin
                if (round != nrr) v = tmix(v, 1'b0);
                v = v ^ rk[kidx];
            end else begin
                v = v ^ rk[kidx];
                if (round != nrr) v = tmix(v, 1'b1);
            end
        end
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] d, input logic m, input logic [1:0] kl);
        int n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        chk("push_ready_timeout", 128'(in_ready), 128'(1));
        in_data    = d;
        in_mode    = m;
        in_key_len = kl;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [127:0] d, input logic m,
                             input logic [1:0] kl, input logic [255:0] key, input bit stall,
                             output logic [127:0] got);
        logic [127:0] exp;
        logic [63:0]  seq, eseq;
        int           nrr, lat, cnt;
        bit           eerr;
        nrr  = (kl == 2'd1) ? 10 : (kl == 2'd2) ? 12 : (kl == 2'd3) ? 14 : 0;
        eerr = (kl == 2'd0);
        exp  = '0;
        if (!eerr) begin
            set_key(key, kl);
            exp = model(d, m, nrr);
        end
        eseq = '0;
        if (!eerr) for (int k = 0; k <= nrr; k++) eseq = (eseq << 4) | 64'(m ? nrr - k : k);
        out_ready = !stall;
        push(d, m, kl);
        lat = 0;
        cnt = 0;
        seq = '0;
        while (!out_valid && lat < 500) begin
            if (subkey_req && (cnt == 0 || seq[3:0] != 4'(subkey_addr))) begin
                seq = (seq << 4) | 64'(subkey_addr);
                cnt++;
            end
            tick();
            lat++;
        end
        chk({tag, "_valid_timeout"}, 128'(out_valid), 128'(1));
        if (!gaps) chk({tag, "_latency"}, 128'(lat), 128'(eerr ? 2 : nrr + 2));
        chk({tag, "_addr_count"}, 128'(cnt), 128'(eerr ? 0 : nrr + 1));
        chk({tag, "_addr_seq"}, 128'(seq), 128'(eseq));
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_err"}, 128'(out_err), 128'(eerr));
        got = out_data;
        if (stall) begin
            for (int i = 0; i < 5; i++) begin
                tick();
                chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
                chk({tag, "_hold_data"}, out_data, exp);
            end
            out_ready = 1'b1;
        end
        tick();
        chk({tag, "_consumed"}, 128'(out_valid), 128'(0));
    endtask

    task automatic pop_check(input string tag, input logic [127:0] exp);
        int n = 0;
        while (!out_valid && n < 500) begin tick(); n++; end
        chk({tag, "_valid_timeout"}, 128'(out_valid), 128'(1));
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_err"}, 128'(out_err), 128'(0));
        tick();
    endtask

    task automatic wait_round(input int min_addr);
        int n = 0;
        while (!(subkey_req && int'(subkey_addr) >= min_addr) && n < 200) begin tick(); n++; end
        chk("wait_round_timeout", 128'(subkey_req), 128'(1));
    endtask

    // ---------------- test sequence ----------------
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        logic [127:0] got, r2, e2;
        logic [255:0] key;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mode = 1'b0;
        in_key_len = 2'd0; in_data = '0; out_ready = 1'b1;
        init_sbox();
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_out_err", 128'(out_err), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_subkey_req", 128'(subkey_req), 128'(0));
        chk("rst_subkey_addr", 128'(subkey_addr), 128'(0));
        tick(); tick();
        @(negedge clk) reset = 1'b0;
        tick();
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        run_block("enc128", PT, 1'b0, 2'd1, key, 1'b0, got);
        chk("enc128_fips", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        run_block("dec192", 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b1, 2'd2, key, 1'b0, got);
        chk("dec192_fips", got, PT);

        set_key(K256, 2'd3);
        r2 = {$urandom, $urandom, $urandom, $urandom};
        e2 = model(r2, 1'b0, 14);
        push(PT, 1'b0, 2'd3);
        push(128'h8ea2b7ca516745bfeafc49904b496089, 1'b1, 2'd3);
        push(r2, 1'b0, 2'd3);
        chk("queue_full_in_ready", 128'(in_ready), 128'(0));
        chk("queue_busy", 128'(busy), 128'(1));
        pop_check("q256_enc", 128'h8ea2b7ca516745bfeafc49904b496089);
        pop_check("q256_dec", PT);
        pop_check("q256_rand", e2);
        chk("queue_idle_busy", 128'(busy), 128'(0));

        gaps = 1'b1;
        for (int i = 0; i < 6; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_block("rand", {$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                      2'($urandom_range(1, 3)), key, (i % 2) == 0, got);
        end
        gaps = 1'b0;

        run_block("keylen0", {$urandom, $urandom, $urandom, $urandom}, 1'b0, 2'd0, K256, 1'b0, got);
        run_block("after_err", PT, 1'b0, 2'd3, K256, 1'b0, got);
        chk("after_err_fips", got, 128'h8ea2b7ca516745bfeafc49904b496089);

        key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        set_key(key, 2'd1);
        for (int i = 0; i < 3; i++) push({$urandom, $urandom, $urandom, $urandom}, 1'b0, 2'd1);
        wait_round(3);
        flush = 1'b1; in_valid = 1'b1; in_data = PT; in_key_len = 2'd1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy", 128'(busy), 128'(0));
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        chk("flush_subkey_req", 128'(subkey_req), 128'(0));

        push(PT, 1'b0, 2'd1);
        wait_round(3);
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_busy", 128'(busy), 128'(0));
        tick(); tick();
        chk("flush_drop_idle", 128'(busy), 128'(0));
        chk("flush_drop_no_out", 128'(out_valid), 128'(0));

        run_block("post_flush", PT, 1'b0, 2'd1, key, 1'b0, got);
        chk("post_flush_fips", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        push(PT, 1'b0, 2'd1);
        wait_round(2);
        #3 reset = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_out_data", out_data, 128'(0));
        chk("arst_out_err", 128'(out_err), 128'(0));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_subkey_req", 128'(subkey_req), 128'(0));
        chk("arst_subkey_addr", 128'(subkey_addr), 128'(0));
        @(negedge clk) reset = 1'b0;
        tick();
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_idle", 128'(busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
